// File: rtl/rtp_result_collector.sv
// ---------------------------------------------------------------------------
// rtp_result_collector
//
// Collects ray results from N_CH parallel channels into a single output FIFO
// and monitors one traversal run from start to finish. A round-robin arbiter
// picks at most one channel per cycle. The block counts accepted rays, and it
// raises a sticky finish flag once NUM_RAYS rays are collected and the FIFO
// has drained. It also freezes the number of cycles the run took.
//
// Optional feature: define RTP_WATCHDOG_EN to add an idle watchdog. The
// watchdog ends a run that accepts nothing for TIMEOUT consecutive cycles,
// and it adds the io_timeout port.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-low
//   io_start        pulse; starts a run (honoured in IDLE or DONE only)
//   io_in_valid     per-channel result valid
//   io_in_ready     per-channel accept, one-hot or zero
//   io_in_hitT      per-channel hitT, channel c at [32c+31:32c]
//   io_in_ray_id    per-channel ray id, same packing
//   io_out_valid    FIFO non-empty
//   io_out_ready    downstream pop
//   io_out_hitT     FIFO head hitT
//   io_out_ray_id   FIFO head ray id
//   io_rtp_finish   sticky run-complete flag
//   io_total_cycle  cycles spent in RUN+DRAIN, frozen once DONE
//   io_ray_count    rays accepted in the current run
//   io_fifo_level   FIFO occupancy (0..DEPTH)
//   io_timeout      watchdog fired (RTP_WATCHDOG_EN only)
// ---------------------------------------------------------------------------
module rtp_result_collector #(
    parameter int N_CH     = 4,
    parameter int DEPTH    = 16,
    parameter int NUM_RAYS = 1024,
    parameter int CYC_W    = 32,
    parameter int TIMEOUT  = 4096
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_start,
    input  logic [N_CH-1:0]           io_in_valid,
    output logic [N_CH-1:0]           io_in_ready,
    input  logic [N_CH*32-1:0]        io_in_hitT,
    input  logic [N_CH*32-1:0]        io_in_ray_id,
    output logic                      io_out_valid,
    input  logic                      io_out_ready,
    output logic [31:0]               io_out_hitT,
    output logic [31:0]               io_out_ray_id,
    output logic                      io_rtp_finish,
    output logic [CYC_W-1:0]          io_total_cycle,
    output logic [31:0]               io_ray_count,
    output logic [$clog2(DEPTH):0]    io_fifo_level
`ifdef RTP_WATCHDOG_EN
    ,
    output logic                      io_timeout
`endif
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Elaboration-time guard on the supported parameter ranges.
    if (N_CH < 1 || N_CH > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        NUM_RAYS < 1 || CYC_W < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("rtp_result_collector: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       rr_q, rr_d;
    logic [AW-1:0]       wr_q, rd_q;
    logic [LW-1:0]       level_q, level_d;
    logic [31:0]         ray_count_q;
    logic [CYC_W-1:0]    total_q;
    logic                finish_q;

    logic [31:0]         mem_hit_q [DEPTH];
    logic [31:0]         mem_id_q  [DEPTH];

    logic                can_accept;
    logic                grant_vld;
    logic [PW-1:0]       grant_idx;
    logic [PW:0]         cand;
    logic [31:0]         push_hit, push_id;
    logic                push, pop;

    // Grants are gated by the registered level. A full FIFO never accepts,
    // even in a cycle that also pops.
    assign can_accept = (state_q == S_RUN) &&
                        (level_q < LW'(DEPTH)) &&
                        (ray_count_q < 32'(NUM_RAYS));

    // Round-robin arbiter. It scans from rr_q upward, wrapping modulo N_CH.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // so this block can never infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, rr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_CH)) begin
                cand = cand - (PW+1)'(N_CH);
            end
            if (!grant_vld && io_in_valid[cand[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
        if (!can_accept) begin
            grant_vld = 1'b0;
        end
    end

    // Select the granted channel's payload and build the one-hot ready.
    always_comb begin
        push_hit    = '0;
        push_id     = '0;
        io_in_ready = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (grant_idx == PW'(j)) begin
                push_hit = io_in_hitT[32*j +: 32];
                push_id  = io_in_ray_id[32*j +: 32];
            end
        end
        if (grant_vld) begin
            io_in_ready[grant_idx] = 1'b1;
        end
    end

    assign push = grant_vld;
    assign pop  = io_out_valid && io_out_ready;

    always_comb begin
        rr_d = rr_q;
        if (grant_vld) begin
            rr_d = (grant_idx == PW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

`ifdef RTP_WATCHDOG_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q;
    logic          timeout_q;
`endif

    // NOTE: storage is not reset. An entry is only readable after it has been
    // written, and io_out_* are gated by io_out_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_hit_q[wr_q] <= push_hit;
            mem_id_q[wr_q]  <= push_id;
        end
    end

    // Control state, FIFO pointers and run counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            ray_count_q <= '0;
            total_q     <= '0;
            finish_q    <= 1'b0;
`ifdef RTP_WATCHDOG_EN
            idle_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. Each
            // right-hand side therefore sees the pre-edge value.
            rr_q    <= rr_d;
            level_q <= level_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE) begin
                        finish_q <= 1'b1;
                    end
                    if (io_start) begin
                        state_q     <= S_RUN;
                        ray_count_q <= '0;
                        total_q     <= '0;
                        finish_q    <= 1'b0;
`ifdef RTP_WATCHDOG_EN
                        idle_q      <= '0;
                        timeout_q   <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (total_q != '1) total_q <= total_q + 1'b1;
                    if (push) ray_count_q <= ray_count_q + 1'b1;
                    if (ray_count_q == 32'(NUM_RAYS)) begin
                        state_q <= S_DRAIN;
                    end
`ifdef RTP_WATCHDOG_EN
                    if (push) begin
                        idle_q <= '0;
                    end else if (idle_q == IW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (total_q != '1) total_q <= total_q + 1'b1;
                    if (level_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_out_valid   = (level_q != '0);
    assign io_out_hitT    = io_out_valid ? mem_hit_q[rd_q] : '0;
    assign io_out_ray_id  = io_out_valid ? mem_id_q[rd_q]  : '0;
    assign io_rtp_finish  = finish_q;
    assign io_total_cycle = total_q;
    assign io_ray_count   = ray_count_q;
    assign io_fifo_level  = level_q;
`ifdef RTP_WATCHDOG_EN
    assign io_timeout     = timeout_q;
`endif

endmodule
